// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types and constants for the AES job scheduler
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      grant_idx_o,
  output logic               grant_valid_o
);

  int cand;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_i) + k) % NUM_REQ;
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IW'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// rtl/aes_job_scheduler.sv - shares one AES core among NUM_REQ requesters, one job in flight
module aes_job_scheduler
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_mode,
  input  logic [NUM_REQ*128-1:0] req_key,
  input  logic [NUM_REQ*128-1:0] req_data,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   core_start,
  output logic                   core_mode,
  output logic [127:0]           core_key,
  output logic [127:0]           core_data,
  input  logic [127:0]           core_result,
  input  logic                   core_done,
  output logic                   busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  sched_state_t   state_q, state_d;
  logic [IW-1:0]  last_grant_q, last_grant_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic           mode_q, mode_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   data_q, data_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic [TW-1:0]      timer_inc;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i         (req_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  assign timer_inc = timer_q + TW'(1);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mode_d       = mode_q;
    key_d        = key_q;
    data_d       = data_q;
    timer_d      = timer_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = '0;
    rsp_valid    = '0;
    core_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          req_ready = arb_grant;
          grant_d   = arb_idx;
          mode_d    = req_mode[arb_idx];
          key_d     = req_key[int'(arb_idx)*128 +: 128];
          data_d    = req_data[int'(arb_idx)*128 +: 128];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        timer_d    = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // Done is checked first so a completion on the timeout cycle still wins.
        timer_d = timer_inc;
        if (core_done) begin
          rsp_data_d = core_result;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (timer_inc == TW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_q      <= '0;
      mode_q       <= 1'b0;
      key_q        <= '0;
      data_q       <= '0;
      timer_q      <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mode_q       <= mode_d;
      key_q        <= key_d;
      data_q       <= data_d;
      timer_q      <= timer_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign core_mode = mode_q;
  assign core_key  = key_q;
  assign core_data = data_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb/tb_aes_job_scheduler.sv - directed self-checking bench for aes_job_scheduler
module tb_aes_job_scheduler;

  localparam int N = 4;
  localparam int T = 32;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
  logic [N*128-1:0] req_key, req_data;
  logic [127:0]   rsp_data, core_key, core_data, core_result;
  logic           rsp_err, core_start, core_mode, core_done, busy;

  logic done_m, done_inj, core_en;
  int   lat, cnt, start_cnt, stab_bad, n_checks, n_fail;
  logic pend, mode_s;
  logic [127:0] key_s, data_s;
  int   grants[$];

  always #5 clk = ~clk;

  aes_job_scheduler #(.NUM_REQ(N), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_mode(core_mode), .core_key(core_key),
    .core_data(core_data), .core_result(core_result), .core_done(core_done),
    .busy(busy)
  );

  // Stand-in for the crypto core: known FIPS-197 vector, otherwise a simple mix.
  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k, input logic [127:0] d);
    if (m && k == FIPS_KEY && d == FIPS_CT) return FIPS_PT;
    return d ^ k ^ {128{m}};
  endfunction

  assign core_done = done_m | done_inj;

  always @(posedge clk) begin
    done_m <= 1'b0;
    if (!rst_n) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (core_start) begin
      pend      <= core_en;
      cnt       <= 1;
      start_cnt <= start_cnt + 1;
      mode_s    <= core_mode;
      key_s     <= core_key;
      data_s    <= core_data;
    end else if (pend) begin
      if (core_key != key_s || core_data != data_s || core_mode != mode_s)
        stab_bad <= stab_bad + 1;
      if (cnt == lat) begin
        done_m      <= 1'b1;
        core_result <= core_fn(mode_s, key_s, data_s);
        pend        <= 1'b0;
      end
      cnt <= cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && |req_ready)
      for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
  end

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!core_start && n < 200) begin tick(); n++; end
    if (!core_start) expect_eq("start_wait_expired", 0, 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 200) begin tick(); n++; end
    if (rsp_valid == '0) expect_eq("rsp_wait_expired", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    if (busy) expect_eq("idle_wait_expired", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [127:0] exp_d;
    n_checks = 0; n_fail = 0; start_cnt = 0; stab_bad = 0;
    done_inj = 0; core_en = 1; lat = 4; done_m = 0; pend = 0; core_result = '0;
    req_valid = '0; req_mode = '0; rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_key[i*128 +: 128]  = {4{32'h1111_0000 + 32'(i)}};
      req_data[i*128 +: 128] = {4{32'hd00d_0000 + 32'(i)}};
    end
    rst_n = 1'b0;
    do_reset();

    // reset state
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_rsp_valid", rsp_valid, 0);
    expect_eq("rst_core_start", core_start, 0);
    expect_eq("rst_core_key", core_key, 0);
    expect_eq("rst_rsp_err", rsp_err, 0);

    // FIPS-197 decrypt on requester 0
    req_key[127:0] = FIPS_KEY; req_data[127:0] = FIPS_CT; req_mode = 4'b0001;
    req_valid = 4'b0001;
    #1;
    expect_eq("dec_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    expect_eq("dec_core_start", core_start, 1);
    expect_eq("dec_core_mode", core_mode, 1);
    expect_eq("dec_core_key", core_key, FIPS_KEY);
    expect_eq("dec_core_data", core_data, FIPS_CT);
    wait_rsp(n);
    expect_eq("dec_rsp_valid", rsp_valid, 4'b0001);
    expect_eq("dec_rsp_data", rsp_data, FIPS_PT);
    expect_eq("dec_rsp_err", rsp_err, 0);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    expect_eq("dec_back_idle", busy, 0);
    req_mode = '0;
    req_key[127:0]  = {4{32'h1111_0000}};
    req_data[127:0] = {4{32'hd00d_0000}};

    // round robin from reset: 0,1,2,3,0
    do_reset();
    grants.delete(); start_cnt = 0; lat = 3;
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    n = 0;
    while (grants.size() < 5 && n < 400) begin tick(); n++; end
    req_valid = '0;
    wait_idle();
    rsp_ready = '0;
    expect_eq("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      expect_eq($sformatf("rr_grant%0d", i), grants[i], i % N);
    expect_eq("rr_start_count", start_cnt, 5);

    // timeout on requester 2
    core_en = 0;
    req_valid = 4'b0100;
    wait_start();
    req_valid = '0;
    wait_rsp(n);
    expect_eq("to_latency", n, T);
    expect_eq("to_rsp_valid", rsp_valid, 4'b0100);
    expect_eq("to_rsp_err", rsp_err, 1);
    expect_eq("to_rsp_data", rsp_data, 0);
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    core_en = 1;

    // requester 1 stalls the response for 5 cycles
    lat = 2;
    req_valid = 4'b0010;
    wait_start();
    req_valid = '0;
    wait_rsp(n);
    exp_d = core_fn(1'b0, req_key[128 +: 128], req_data[128 +: 128]);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      expect_eq("hold_rsp_valid", rsp_valid, 4'b0010);
      expect_eq("hold_rsp_data", rsp_data, exp_d);
      expect_eq("hold_core_start", core_start, 0);
      expect_eq("hold_req_ready", req_ready, 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
    expect_eq("hold_released", busy, 0);

    // reset while waiting on the core
    core_en = 0;
    req_valid = 4'b1000;
    wait_start();
    req_valid = '0;
    tick(); tick(); tick();
    expect_eq("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    expect_eq("mid_rst_busy", busy, 0);
    expect_eq("mid_rst_core_key", core_key, 0);
    expect_eq("mid_rst_core_data", core_data, 0);
    expect_eq("mid_rst_rsp_data", rsp_data, 0);
    expect_eq("mid_rst_rsp_valid", rsp_valid, 0);
    expect_eq("mid_rst_core_start", core_start, 0);
    rst_n = 1'b1;
    core_en = 1; lat = 2;
    req_valid = 4'b0110;
    #1;
    expect_eq("mid_first_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_rsp(n);
    expect_eq("mid_rsp_valid", rsp_valid, 4'b0010);
    rsp_ready = 4'b1111;
    tick();
    rsp_ready = '0;

    // done on the same cycle the timeout would fire
    lat = T - 2;
    req_valid = 4'b0001;
    wait_start();
    req_valid = '0;
    wait_rsp(n);
    expect_eq("tie_latency", n, T);
    expect_eq("tie_rsp_err", rsp_err, 0);
    expect_eq("tie_rsp_data", rsp_data, core_fn(1'b0, req_key[127:0], req_data[127:0]));
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;

    // stray done while idle
    done_inj = 1;
    tick();
    done_inj = 0;
    tick();
    expect_eq("stray_busy", busy, 0);
    expect_eq("stray_rsp_valid", rsp_valid, 0);
    expect_eq("hold_regs_stable", stab_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1, "global time limit reached");
  end

endmodule
